// File: rtl/v68k_pkg.sv
// Shared definitions for the 68k-style datapath blocks: FSM encodings,
// register-index constants and transfer size steps.
package v68k_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_XFER = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Register indices: bit 3 selects the address bank
    localparam logic [3:0] REG_D0 = 4'd0;
    localparam logic [3:0] REG_D1 = 4'd1;
    localparam logic [3:0] REG_D2 = 4'd2;
    localparam logic [3:0] REG_D3 = 4'd3;
    localparam logic [3:0] REG_D4 = 4'd4;
    localparam logic [3:0] REG_D5 = 4'd5;
    localparam logic [3:0] REG_D6 = 4'd6;
    localparam logic [3:0] REG_D7 = 4'd7;
    localparam logic [3:0] REG_A0 = 4'd8;
    localparam logic [3:0] REG_A1 = 4'd9;
    localparam logic [3:0] REG_A2 = 4'd10;
    localparam logic [3:0] REG_A3 = 4'd11;
    localparam logic [3:0] REG_A4 = 4'd12;
    localparam logic [3:0] REG_A5 = 4'd13;
    localparam logic [3:0] REG_A6 = 4'd14;
    localparam logic [3:0] REG_A7 = 4'd15;

    localparam int WORD_STEP = 2;
    localparam int LONG_STEP = 4;

endpackage

// File: rtl/mask_priority_encoder.sv
// Picks the next register from a pending mask: lowest set bit for ascending
// scans, highest set bit for predecrement (descending) scans.
module mask_priority_encoder
    import v68k_pkg::*;
(
    input  logic [15:0] pend,
    input  logic        descending,
    output logic [3:0]  idx,
    output logic        any
);

    // Later loop iterations override earlier ones, so scan order decides priority
    always_comb begin
        idx = REG_D0;
        any = |pend;
        if (descending) begin
            for (int i = 0; i < 16; i++) begin
                if (pend[i]) idx = i[3:0];
                else         idx = idx;
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (pend[i]) idx = i[3:0];
                else         idx = idx;
            end
        end
    end

endmodule

// File: rtl/movem_sequencer.sv
// MOVEM transfer engine: walks a register mask and moves one register per
// memory handshake, in either direction, with optional predecrement addressing.
module movem_sequencer
    import v68k_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       mask,
    input  logic              dir,
    input  logic              predec,
    input  logic              size,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] final_addr,
    output logic [3:0]        reg_sel,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t              state_r;
    logic [15:0]         pend_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   final_addr_r;
    logic                dir_r;
    logic                predec_r;
    logic                size_r;

    logic [3:0]          idx_s;
    logic                any_s;
    logic                xfer_s;
    logic                ack_s;
    logic [15:0]         pend_next_s;
    logic [ADDR_W-1:0]   step_s;
    logic [ADDR_W-1:0]   start_step_s;
    logic [ADDR_W-1:0]   addr_next_s;

    mask_priority_encoder u_prio (
        .pend       (pend_r),
        .descending (predec_r),
        .idx        (idx_s),
        .any        (any_s)
    );

    assign xfer_s       = (state_r == ST_XFER) && any_s;
    assign ack_s        = xfer_s && mem_ack;
    assign pend_next_s  = pend_r & ~(16'd1 << idx_s);
    assign step_s       = size_r ? ADDR_W'(LONG_STEP) : ADDR_W'(WORD_STEP);
    assign start_step_s = size ? ADDR_W'(LONG_STEP) : ADDR_W'(WORD_STEP);
    assign addr_next_s  = predec_r ? (addr_r - step_s) : (addr_r + step_s);

    // Sequencer state, captured operands and address walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pend_r       <= 16'd0;
            addr_r       <= '0;
            final_addr_r <= '0;
            dir_r        <= 1'b0;
            predec_r     <= 1'b0;
            size_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pend_r   <= mask;
                        dir_r    <= dir;
                        predec_r <= predec;
                        size_r   <= size;
                        if (mask == 16'd0) begin
                            addr_r       <= base_addr;
                            final_addr_r <= base_addr;
                            state_r      <= ST_DONE;
                        end else begin
                            addr_r  <= predec ? (base_addr - start_step_s) : base_addr;
                            state_r <= ST_XFER;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (ack_s) begin
                        pend_r <= pend_next_s;
                        addr_r <= addr_next_s;
                        // Predecrement leaves An at the last address used
                        if (pend_next_s == 16'd0) begin
                            final_addr_r <= predec_r ? addr_r : addr_next_s;
                            state_r      <= ST_DONE;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_r != ST_IDLE);
    assign done       = (state_r == ST_DONE);
    assign final_addr = final_addr_r;
    assign reg_sel    = idx_s;
    assign mem_req    = xfer_s;
    assign mem_we     = xfer_s && !dir_r;
    assign mem_addr   = addr_r;
    assign reg_we     = ack_s && dir_r;

    // Word loads sign-extend into the register; word stores zero-extend onto the bus
    assign reg_wdata = !reg_we ? '0 :
                       size_r  ? mem_rdata :
                                 {{(DATA_W-16){mem_rdata[15]}}, mem_rdata[15:0]};
    assign mem_wdata = !xfer_s ? '0 :
                       size_r  ? reg_rdata :
                                 {{(DATA_W-16){1'b0}}, reg_rdata[15:0]};

endmodule

// File: tb/tb_movem_sequencer.sv
// Self-checking bench for movem_sequencer: register file and memory responder
// models, a transfer scoreboard and a table of MOVEM operations.
module tb_movem_sequencer;

    logic        clk, rst_n, start, dir, predec, size, mem_ack;
    logic [15:0] mask;
    logic [31:0] base_addr, reg_rdata, mem_rdata;
    logic        busy, done, reg_we, mem_req, mem_we;
    logic [31:0] final_addr, reg_wdata, mem_addr, mem_wdata;
    logic [3:0]  reg_sel;

    movem_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .dir(dir),
        .predec(predec), .size(size), .base_addr(base_addr), .busy(busy),
        .done(done), .final_addr(final_addr), .reg_sel(reg_sel), .reg_we(reg_we),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic [15:0] mask;
        logic        dir, predec, size;
        logic [31:0] base;
        int          wt;
        logic [31:0] fin;
        int          lat;
        bit          scr;
    } vec_t;

    typedef struct {
        logic        mwe;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rsel;
    } xfer_t;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, cur_wait = 0, wcnt = 0;
    int req_cycles = 0, we_cycles = 0, acks_seen = 0;
    logic [31:0] rf [16];
    logic [31:0] exp_rf [16];
    logic [31:0] snap [16];
    xfer_t sb[$];
    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign reg_rdata = rf[reg_sel];
    always @(posedge clk) if (reg_we) rf[reg_sel] <= reg_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_2000: mem_data = 32'hABCD_8001;
            32'h0000_2002: mem_data = 32'h5555_0042;
            default:       mem_data = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Expected transfer list, derived from the mask and addressing mode
    task automatic push_expected(input vec_t v);
        xfer_t t;
        int k = 0;
        logic [31:0] step, md;
        step = v.size ? 32'd4 : 32'd2;
        for (int j = 0; j < 16; j++) begin
            int i = v.predec ? 15 - j : j;
            if (v.mask[i]) begin
                t.rsel = i[3:0];
                t.addr = v.predec ? v.base - (k + 1) * step : v.base + k * step;
                t.mwe  = !v.dir;
                if (!v.dir) begin
                    t.data = v.size ? exp_rf[i] : {16'h0000, exp_rf[i][15:0]};
                end else begin
                    md = mem_data(t.addr);
                    t.data = v.size ? md : {{16{md[15]}}, md[15:0]};
                    exp_rf[i] = t.data;
                end
                sb.push_back(t);
                k++;
            end
        end
    endtask

    // Memory responder with programmable wait states, stray acks and scoreboard
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            req_cycles++;
            if (wcnt >= cur_wait) begin
                mem_ack = 1'b1; mem_rdata = mem_data(mem_addr); wcnt = 0;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom; wcnt++;
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; wcnt = 0;
        end
        #1;
        if (rst_n && mem_req && mem_ack) begin
            xfer_t t;
            acks_seen++;
            if (reg_we) we_cycles++;
            if (sb.size() == 0) begin
                chk("unexpected_xfer", mem_addr, 32'hxxxx_xxxx);
            end else begin
                t = sb.pop_front();
                chk("mem_addr", mem_addr, t.addr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, t.mwe});
                chk("reg_sel", {28'd0, reg_sel}, {28'd0, t.rsel});
                if (t.mwe) begin
                    chk("mem_wdata", mem_wdata, t.data);
                    chk("reg_we_on_store", {31'd0, reg_we}, 32'd0);
                end else begin
                    chk("reg_we_on_load", {31'd0, reg_we}, 32'd1);
                    chk("reg_wdata", reg_wdata, t.data);
                end
            end
        end else if (reg_we) begin
            chk("reg_we_outside_ack", {31'd0, reg_we}, 32'd0);
        end
    end

    task automatic run_op(input vec_t v);
        int start_cyc, lat;
        bit seen = 0;
        cur_wait = v.wt;
        push_expected(v);
        @(negedge clk);
        start = 1'b1; mask = v.mask; dir = v.dir; predec = v.predec;
        size = v.size; base_addr = v.base;
        start_cyc = cyc; req_cycles = 0; we_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        mask = 16'($urandom); dir = 1'($urandom); predec = 1'($urandom);
        size = 1'($urandom); base_addr = $urandom;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (done) begin
                seen = 1; lat = cyc - start_cyc; start = 1'b0;
            end else begin
                start = (v.scr && (k % 4 == 2)) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", lat, v.lat);
            chk("final_addr", final_addr, v.fin);
            chk("busy_in_done", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("busy_after", {31'd0, busy}, 32'd0);
            chk("final_held", final_addr, v.fin);
            chk("req_cycles", req_cycles, v.lat - 1);
            chk("reg_we_cycles", we_cycles, v.dir ? $countones(v.mask) : 0);
            chk("sb_empty", sb.size(), 0);
        end
    endtask

    initial begin
        vec_t rv;
        rst_n = 1'b0; start = 1'b0; mask = 16'd0; dir = 1'b0; predec = 1'b0;
        size = 1'b0; base_addr = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h0101_0101 * (i + 1) + 32'h8000_8000;
        rf[0] = 32'hF00F_F00F;
        rf[2] = 32'h1234_5678;
        for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];

        //          mask      dir   pre   size  base           wt fin            lat scr
        vecs[0] = '{16'h0005, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 1, 32'h0000_1008,  5, 0};
        vecs[1] = '{16'h8100, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 1, 32'h0000_2004,  5, 0};
        vecs[2] = '{16'h0003, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 0, 32'h0000_2FF8,  3, 0};
        vecs[3] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 0, 32'h0000_4000,  1, 0};
        vecs[4] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 0, 32'h0000_5040, 17, 1};
        vecs[5] = '{16'h00F0, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 0, 32'hFFFF_FFFA,  5, 0};
        vecs[6] = '{16'h8001, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 2, 32'h0000_0004,  7, 1};
        vecs[7] = '{16'h0006, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 0, 32'h0000_6004,  3, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_req", {30'd0, mem_req, mem_we}, 32'd0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_reg_sel", {28'd0, reg_sel}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_final", final_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);
        chk("A0_loaded", rf[8], 32'hFFFF_8001);
        chk("A7_loaded", rf[15], 32'h0000_0042);

        // Reset during the second transfer of a load
        for (int i = 0; i < 16; i++) snap[i] = exp_rf[i];
        rv = '{16'h000F, 1'b1, 1'b0, 1'b1, 32'h0000_7000, 1, 32'h0, 0, 0};
        cur_wait = 1;
        push_expected(rv);
        acks_seen = 0;
        @(negedge clk);
        start = 1'b1; mask = rv.mask; dir = 1'b1; predec = 1'b0; size = 1'b1;
        base_addr = rv.base;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && acks_seen < 1; k++) @(negedge clk);
        chk("first_ack_seen", acks_seen, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {30'd0, busy, done}, 32'd0);
        chk("mid_rst_req", {30'd0, mem_req, mem_we}, 32'd0);
        chk("mid_rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("mid_rst_sel", {28'd0, reg_sel}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_final", final_addr, 32'd0);
        sb.delete();
        for (int i = 0; i < 16; i++) exp_rf[i] = snap[i];
        exp_rf[0] = mem_data(32'h0000_7000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("D0_written_before_rst", rf[0], exp_rf[0]);
        chk("D1_untouched", rf[1], snap[1]);
        chk("D2_untouched", rf[2], snap[2]);
        chk("D3_untouched", rf[3], snap[3]);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        run_op('{16'h0009, 1'b0, 1'b0, 1'b1, 32'h0000_8000, 0, 32'h0000_8008, 3, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
